// File: rtl/fabric_memory_mp.sv
// fabric_memory_mp: single-array memory with LD_COUNT round-robin load
// channels and one store channel, all valid/ready handshaked. Loads return
// registered data plus a done token; stores return a done token. Out-of-range
// accesses are accepted, made harmless, and latched into a sticky error flag.
module fabric_memory_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 64,
    parameter int DEPTH      = 256,
    parameter int LD_COUNT   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [LD_COUNT-1:0]            ldaddr_valid,
    output logic [LD_COUNT-1:0]            ldaddr_ready,
    input  logic [LD_COUNT*ADDR_WIDTH-1:0] ldaddr_data,
    output logic [LD_COUNT-1:0]            lddata_valid,
    input  logic [LD_COUNT-1:0]            lddata_ready,
    output logic [LD_COUNT*DATA_WIDTH-1:0] lddata_data,
    output logic [LD_COUNT-1:0]            lddone_valid,
    input  logic [LD_COUNT-1:0]            lddone_ready,
    output logic [LD_COUNT-1:0]            lddone_data,
    input  logic                           staddr_valid,
    output logic                           staddr_ready,
    input  logic [ADDR_WIDTH-1:0]          staddr_data,
    input  logic                           stdata_valid,
    output logic                           stdata_ready,
    input  logic [DATA_WIDTH-1:0]          stdata_data,
    output logic                           stdone_valid,
    input  logic                           stdone_ready,
    output logic                           stdone_data,
    output logic                           error_valid,
    output logic [15:0]                    error_code
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = (LD_COUNT > 1) ? $clog2(LD_COUNT) : 1;
    // One extra bit so the range check sees the whole address, even when
    // ADDR_WIDTH is just wide enough to hold DEPTH-1.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [LD_COUNT-1:0]   ld_elig;
    logic                  grant_valid;
    logic [PTR_W-1:0]      grant_idx;
    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      rr_ptr_next;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic                  ld_in_range;
    logic [DATA_WIDTH-1:0] ld_word;
    logic                  st_fire;
    logic                  st_in_range;
    logic                  err_ld;
    logic                  err_st;

    assign lddone_data = '0;
    assign stdone_data = 1'b0;

    // Store is taken when both halves are present and the done slot frees up.
    assign st_fire      = rst_n && staddr_valid && stdata_valid && (!stdone_valid || stdone_ready);
    assign staddr_ready = st_fire;
    assign stdata_ready = st_fire;
    assign st_in_range  = {1'b0, staddr_data} < DEPTH_EXT;

    // A load channel may compete only when both of its response registers are free or draining.
    always_comb begin
        ld_elig = '0;
        for (int i = 0; i < LD_COUNT; i++) begin
            ld_elig[i] = rst_n && ldaddr_valid[i]
                         && (!lddata_valid[i] || lddata_ready[i])
                         && (!lddone_valid[i] || lddone_ready[i]);
        end
    end

    // Round-robin pick: first eligible channel scanning upward from the pointer.
    always_comb begin
        int sum;
        logic [PTR_W-1:0] cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        sum         = 0;
        cand        = '0;
        for (int k = 0; k < LD_COUNT; k++) begin
            sum = int'(rr_ptr) + k;
            if (sum >= LD_COUNT) begin
                sum = sum - LD_COUNT;
            end
            cand = PTR_W'(sum);
            if (!grant_valid && ld_elig[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // One-hot accept for the winner and mux of its address.
    always_comb begin
        ldaddr_ready = '0;
        ld_addr      = '0;
        for (int i = 0; i < LD_COUNT; i++) begin
            if (grant_valid && grant_idx == PTR_W'(i)) begin
                ldaddr_ready[i] = 1'b1;
                ld_addr         = ldaddr_data[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign ld_in_range = {1'b0, ld_addr} < DEPTH_EXT;
    assign ld_word     = ld_in_range ? mem[ld_addr[IDX_W-1:0]] : '0;
    assign err_ld      = grant_valid && !ld_in_range;
    assign err_st      = st_fire && !st_in_range;
    assign rr_ptr_next = (grant_idx == PTR_W'(LD_COUNT-1)) ? '0 : grant_idx + 1'b1;

    // Storage array; a load in the same cycle still sees the old word.
    always_ff @(posedge clk) begin
        if (st_fire && st_in_range) begin
            mem[staddr_data[IDX_W-1:0]] <= stdata_data;
        end
    end

    // Per-channel response registers: loaded on grant, each valid drains on its own handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lddata_valid <= '0;
            lddone_valid <= '0;
            lddata_data  <= '0;
        end else begin
            for (int i = 0; i < LD_COUNT; i++) begin
                if (grant_valid && grant_idx == PTR_W'(i)) begin
                    lddata_valid[i] <= 1'b1;
                    lddone_valid[i] <= 1'b1;
                    lddata_data[i*DATA_WIDTH +: DATA_WIDTH] <= ld_word;
                end else begin
                    if (lddata_ready[i]) begin
                        lddata_valid[i] <= 1'b0;
                    end
                    if (lddone_ready[i]) begin
                        lddone_valid[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Arbitration pointer, store done token and the sticky first-error record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            stdone_valid <= 1'b0;
            error_valid  <= 1'b0;
            error_code   <= 16'h0000;
        end else begin
            if (grant_valid) begin
                rr_ptr <= rr_ptr_next;
            end
            if (st_fire) begin
                stdone_valid <= 1'b1;
            end else if (stdone_ready) begin
                stdone_valid <= 1'b0;
            end
            if (!error_valid && (err_ld || err_st)) begin
                error_valid <= 1'b1;
                error_code  <= err_ld ? 16'h0001 : 16'h0002;
            end
        end
    end

endmodule

// File: tb/tb_fabric_memory_mp.sv
// tb_fabric_memory_mp: randomized and directed stimulus against a queue-based
// scoreboard. A predictor models memory, slot occupancy, round-robin order and
// the sticky error; a monitor pops expected load data as responses appear.
module tb_fabric_memory_mp;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 16;
    localparam int LDC   = 2;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic [LDC-1:0]   ldaddr_valid, ldaddr_ready;
    logic [LDC*AW-1:0] ldaddr_data;
    logic [LDC-1:0]   lddata_valid, lddata_ready;
    logic [LDC*DW-1:0] lddata_data;
    logic [LDC-1:0]   lddone_valid, lddone_ready, lddone_data;
    logic             staddr_valid, staddr_ready;
    logic [AW-1:0]    staddr_data;
    logic             stdata_valid, stdata_ready;
    logic [DW-1:0]    stdata_data;
    logic             stdone_valid, stdone_ready, stdone_data;
    logic             error_valid;
    logic [15:0]      error_code;

    always #5 clk = ~clk;

    fabric_memory_mp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LD_COUNT(LDC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ldaddr_valid(ldaddr_valid), .ldaddr_ready(ldaddr_ready), .ldaddr_data(ldaddr_data),
        .lddata_valid(lddata_valid), .lddata_ready(lddata_ready), .lddata_data(lddata_data),
        .lddone_valid(lddone_valid), .lddone_ready(lddone_ready), .lddone_data(lddone_data),
        .staddr_valid(staddr_valid), .staddr_ready(staddr_ready), .staddr_data(staddr_data),
        .stdata_valid(stdata_valid), .stdata_ready(stdata_ready), .stdata_data(stdata_data),
        .stdone_valid(stdone_valid), .stdone_ready(stdone_ready), .stdone_data(stdone_data),
        .error_valid(error_valid), .error_code(error_code)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state
    logic [DW-1:0] mem_m [DEPTH];
    bit            pend_data [LDC];
    bit            pend_done [LDC];
    bit            pend_st;
    int            p_m;
    bit            err_m;
    logic [15:0]   code_m;
    int            grant_cnt [LDC];
    logic [LDC-1:0] seen_ld_rdy;
    bit            seen_st_rdy;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Predictor: compare handshake-level outputs with the model, then advance the model.
    always @(negedge clk) begin
        int g, best, d;
        logic [AW-1:0] a;
        bit ld_oor, st_oor, st_acc;
        logic [LDC-1:0] exp_grant;
        if (!rst_n) begin
            exp_q.delete();
            for (int c = 0; c < LDC; c++) begin
                pend_data[c] = 0;
                pend_done[c] = 0;
            end
            pend_st = 0; p_m = 0; err_m = 0; code_m = 16'h0;
            seen_ld_rdy = '0; seen_st_rdy = 0;
            checkOutput("rst_lddata_valid", 64'(lddata_valid), 64'h0);
            checkOutput("rst_lddone_valid", 64'(lddone_valid), 64'h0);
            checkOutput("rst_stdone_valid", 64'(stdone_valid), 64'h0);
            checkOutput("rst_ldaddr_ready", 64'(ldaddr_ready), 64'h0);
            checkOutput("rst_st_ready", 64'({staddr_ready, stdata_ready}), 64'h0);
            checkOutput("rst_error", 64'({error_valid, error_code}), 64'h0);
            checkOutput("rst_lddata_data", 64'(lddata_data), 64'h0);
        end else begin
            for (int c = 0; c < LDC; c++) begin
                checkOutput($sformatf("lddata_valid[%0d]", c), 64'(lddata_valid[c]), 64'(pend_data[c]));
                checkOutput($sformatf("lddone_valid[%0d]", c), 64'(lddone_valid[c]), 64'(pend_done[c]));
            end
            checkOutput("stdone_valid", 64'(stdone_valid), 64'(pend_st));
            checkOutput("error_valid", 64'(error_valid), 64'(err_m));
            checkOutput("error_code", 64'(error_code), 64'(code_m));

            st_acc = staddr_valid && stdata_valid && (!pend_st || stdone_ready);
            checkOutput("staddr_ready", 64'(staddr_ready), 64'(st_acc));
            checkOutput("stdata_ready", 64'(stdata_ready), 64'(st_acc));

            // Winner is the eligible channel closest after the pointer (cyclic distance)
            g = -1; best = LDC;
            for (int c = 0; c < LDC; c++) begin
                if (ldaddr_valid[c] && (!pend_data[c] || lddata_ready[c]) && (!pend_done[c] || lddone_ready[c])) begin
                    d = (c - p_m + LDC) % LDC;
                    if (d < best) begin
                        best = d;
                        g = c;
                    end
                end
            end
            exp_grant = '0;
            if (g >= 0) exp_grant[g] = 1'b1;
            checkOutput("ldaddr_ready", 64'(ldaddr_ready), 64'(exp_grant));

            seen_ld_rdy = ldaddr_ready;
            seen_st_rdy = staddr_ready && stdata_ready;
            for (int c = 0; c < LDC; c++) begin
                if (ldaddr_ready[c]) grant_cnt[c]++;
                if (pend_data[c] && lddata_ready[c]) pend_data[c] = 0;
                if (pend_done[c] && lddone_ready[c]) pend_done[c] = 0;
            end
            if (pend_st && stdone_ready) pend_st = 0;

            ld_oor = 0; st_oor = 0;
            if (g >= 0) begin
                a = ldaddr_data[g*AW +: AW];
                ld_oor = (a >= DEPTH);
                exp_q.push_back('{g, ld_oor ? '0 : mem_m[int'(a)]});
                pend_data[g] = 1; pend_done[g] = 1;
                p_m = (g + 1) % LDC;
            end
            if (st_acc) begin
                st_oor = (staddr_data >= DEPTH);
                if (!st_oor) mem_m[int'(staddr_data)] = stdata_data;
                pend_st = 1;
            end
            if (!err_m && (ld_oor || st_oor)) begin
                err_m  = 1;
                code_m = ld_oor ? 16'h0001 : 16'h0002;
            end
        end
    end

    // Monitor: whenever load data is presented, compare with the oldest expectation for that channel.
    always @(negedge clk) begin
        int idx;
        if (rst_n) begin
            for (int c = 0; c < LDC; c++) begin
                if (lddata_valid[c]) begin
                    idx = -1;
                    for (int j = 0; j < exp_q.size(); j++) begin
                        if (idx < 0 && exp_q[j].ch == c) idx = j;
                    end
                    if (idx < 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL unexpected_lddata[%0d]: actual=%0h expected=none", c, lddata_data[c*DW +: DW]);
                    end else begin
                        checkOutput($sformatf("lddata_data[%0d]", c), 64'(lddata_data[c*DW +: DW]), 64'(exp_q[idx].data));
                        if (lddata_ready[c]) exp_q.delete(idx);
                    end
                end
                if (lddone_valid[c]) checkOutput($sformatf("lddone_data[%0d]", c), 64'(lddone_data[c]), 64'h0);
            end
            if (stdone_valid) checkOutput("stdone_data", 64'(stdone_data), 64'h0);
        end
    end

    // One random cycle; a held valid only changes after it has transferred.
    task automatic applyStimulus(input int ld_pct, input int st_pct, input int rdy_pct);
        @(posedge clk); #1;
        for (int c = 0; c < LDC; c++) begin
            if (!ldaddr_valid[c] || seen_ld_rdy[c]) begin
                ldaddr_valid[c] = ($urandom_range(0, 99) < ld_pct);
                ldaddr_data[c*AW +: AW] = AW'($urandom_range(0, DEPTH-1));
            end
            lddata_ready[c] = ($urandom_range(0, 99) < rdy_pct);
            lddone_ready[c] = ($urandom_range(0, 99) < rdy_pct);
        end
        if (!staddr_valid || seen_st_rdy) begin
            staddr_valid = ($urandom_range(0, 99) < st_pct);
            stdata_valid = staddr_valid;
            staddr_data  = AW'($urandom_range(0, DEPTH-1));
            stdata_data  = $urandom;
        end
        stdone_ready = ($urandom_range(0, 99) < rdy_pct);
    endtask

    task automatic drain(input int n);
        repeat (n) applyStimulus(0, 0, 100);
    endtask

    task automatic run_store(input logic [AW-1:0] a, input logic [DW-1:0] dat);
        int n = 0;
        @(posedge clk); #1;
        staddr_valid = 1; staddr_data = a; stdata_valid = 1; stdata_data = dat;
        @(negedge clk); #1;
        while (!seen_st_rdy && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (!seen_st_rdy) begin
            checks++; errors++;
            $display("[TB] FAIL store_timeout: actual=no_accept required=accept addr=%0h", a);
        end
        @(posedge clk); #1;
        staddr_valid = 0; stdata_valid = 0;
    endtask

    task automatic run_load(input int ch, input logic [AW-1:0] a);
        int n = 0;
        @(posedge clk); #1;
        ldaddr_valid[ch] = 1; ldaddr_data[ch*AW +: AW] = a;
        @(negedge clk); #1;
        while (!seen_ld_rdy[ch] && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (!seen_ld_rdy[ch]) begin
            checks++; errors++;
            $display("[TB] FAIL load_timeout: actual=no_accept required=accept ch=%0d", ch);
        end
        @(posedge clk); #1;
        ldaddr_valid[ch] = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        ldaddr_valid = '0; ldaddr_data = '0; lddata_ready = '0; lddone_ready = '0;
        staddr_valid = 0; staddr_data = '0; stdata_valid = 0; stdata_data = '0; stdone_ready = 0;
        for (int c = 0; c < LDC; c++) grant_cnt[c] = 0;
        #2 rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        lddata_ready = '1; lddone_ready = '1; stdone_ready = 1;
        rst_n = 1;
        $display("[TB] reset released");

        // Fill memory; address 5 carries the directed pattern
        for (int a = 0; a < DEPTH; a++) begin
            run_store(AW'(a), (a == 5) ? 32'hDEADBEEF : $urandom);
        end
        run_load(0, 5);
        drain(3);

        $display("[TB] random traffic");
        repeat (300) applyStimulus(60, 50, 70);
        drain(6);

        // Both channels requesting every cycle with full readiness
        applyStimulus(100, 0, 100);
        for (int c = 0; c < LDC; c++) grant_cnt[c] = 0;
        repeat (9) applyStimulus(100, 0, 100);
        @(negedge clk); #1;
        checkOutput("alt_total_grants", 64'(grant_cnt[0] + grant_cnt[1]), 64'd10);
        checkOutput("alt_ch0_grants", 64'(grant_cnt[0]), 64'd5);

        // Channel 0 data path stalled for four cycles
        for (int c = 0; c < LDC; c++) grant_cnt[c] = 0;
        repeat (4) begin
            applyStimulus(100, 0, 100);
            lddata_ready[0] = 0;
        end
        @(negedge clk); #1;
        checkOutput("stall_ch1_served", 64'(grant_cnt[1] >= 3), 64'd1);
        checkOutput("stall_ch0_limited", 64'(grant_cnt[0] <= 1), 64'd1);
        drain(4);

        // Same-cycle store and load to address 7
        run_store(7, 32'd1);
        @(posedge clk); #1;
        lddata_ready = '1; lddone_ready = '1; stdone_ready = 1;
        ldaddr_valid = 2'b01; ldaddr_data[0 +: AW] = 7;
        staddr_valid = 1; staddr_data = 7; stdata_valid = 1; stdata_data = 32'd2;
        @(negedge clk); #1;
        checkOutput("same_cycle_ld_accept", 64'(seen_ld_rdy), 64'h1);
        checkOutput("same_cycle_st_accept", 64'(seen_st_rdy), 64'h1);
        @(posedge clk); #1;
        ldaddr_valid = '0; staddr_valid = 0; stdata_valid = 0;
        run_load(1, 7);
        drain(3);

        // Out-of-range load then store; the first code must stick
        $display("[TB] out-of-range accesses");
        run_load(0, AW'(DEPTH));
        run_store(AW'(DEPTH + 1), 32'h12345678);
        drain(3);
        checkOutput("oor_error_valid", 64'(error_valid), 64'h1);
        checkOutput("oor_error_code", 64'(error_code), 64'h0001);
        run_store(16'h0105, 32'hA5A5A5A5);
        run_load(1, 5);
        drain(3);

        // Reset while a load response and a store done are outstanding
        @(posedge clk); #1;
        lddata_ready = '0; lddone_ready = '0; stdone_ready = 0;
        run_load(1, 4);
        run_store(9, 32'hCAFEF00D);
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        checkOutput("async_lddata_valid", 64'(lddata_valid), 64'h0);
        checkOutput("async_stdone_valid", 64'(stdone_valid), 64'h0);
        staddr_valid = 1; staddr_data = 3; stdata_valid = 1; stdata_data = 32'h0BADF00D;
        lddata_ready = '1; lddone_ready = '1; stdone_ready = 1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        @(negedge clk); #1;
        checkOutput("first_edge_store_accept", 64'(seen_st_rdy), 64'h1);
        @(posedge clk); #1;
        staddr_valid = 0; stdata_valid = 0;
        drain(4);
        run_load(0, 3);
        drain(4);
        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
